// File: rtl/turn_controller.sv
// turn_controller: owns the tic-tac-toe board and sequences human/AI turns,
// move legality, win/draw detection and the AI forfeit timeout.
module turn_controller #(
  parameter bit HUMAN_FIRST = 1'b1,
  parameter int AI_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] human_move_select,
  input  logic       human_move_en,
  input  logic [3:0] ai_move_select,
  input  logic       ai_move_en,
  output logic       ai_move_req,
  output logic [5:0] top,
  output logic [5:0] middle,
  output logic [5:0] bottom,
  output logic       turn,
  output logic       request_new_move_select,
  output logic       valid_move,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count,
  output logic       ai_timeout
);
  typedef enum logic [2:0] {IDLE, HUMAN_TURN, AI_TURN, CHECK, DONE} state_t;
  state_t state, next_state;
  logic [1:0] cells [9];
  logic [7:0] ai_cnt;
  logic [8:0] xb, ob;
  logic [15:0] occ;
  logic [3:0] sel;
  logic [1:0] code, next_winner;
  logic en, acc, rej, tmo, x_win, o_win, full;
  function automatic logic has_line(input logic [8:0] b);
    return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) | (b[0] & b[3] & b[6]) |
           (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction
  always_comb begin
    xb = '0;
    ob = '0;
    for (int i = 0; i < 9; i++) begin
      xb[i] = cells[i] == 2'b01;
      ob[i] = cells[i] == 2'b10;
    end
  end
  // out-of-range selects 9..15 look like occupied cells, so one lookup covers both checks
  assign occ   = {7'h7f, xb | ob};
  assign sel   = state == AI_TURN ? ai_move_select : human_move_select;
  assign code  = state == AI_TURN ? 2'b10 : 2'b01;
  assign en    = state == AI_TURN ? ai_move_en : state == HUMAN_TURN ? human_move_en : 1'b0;
  assign acc   = en && !occ[sel];
  assign rej   = en && occ[sel];
  assign tmo   = state == AI_TURN && !acc && ai_cnt == 8'(AI_TIMEOUT - 1);
  assign x_win = has_line(xb);
  assign o_win = has_line(ob);
  assign full  = move_count == 4'd9;
  assign top    = {cells[0], cells[1], cells[2]};
  assign middle = {cells[3], cells[4], cells[5]};
  assign bottom = {cells[6], cells[7], cells[8]};
  always_comb begin
    next_state = state;
    if (start) next_state = HUMAN_FIRST ? HUMAN_TURN : AI_TURN;
    else
      case (state)
        HUMAN_TURN, AI_TURN: next_state = acc ? CHECK : tmo ? DONE : state;
        CHECK: next_state = (x_win || o_win || full) ? DONE : turn ? HUMAN_TURN : AI_TURN;
        default: next_state = state;
      endcase
  end
  assign next_winner = start ? 2'b00 : tmo ? 2'b01 : state != CHECK ? winner :
                       x_win ? 2'b01 : o_win ? 2'b10 : full ? 2'b11 : winner;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
      ai_cnt <= '0;
      ai_move_req <= 1'b0;
      turn <= 1'b0;
      request_new_move_select <= 1'b0;
      valid_move <= 1'b0;
      game_over <= 1'b0;
      winner <= 2'b00;
      move_count <= '0;
      ai_timeout <= 1'b0;
    end else begin
      state <= next_state;
      for (int i = 0; i < 9; i++)
        cells[i] <= start ? 2'b00 : (acc && sel == 4'(i)) ? code : cells[i];
      ai_cnt <= (!start && state == AI_TURN && next_state == AI_TURN) ? ai_cnt + 8'd1 : 8'd0;
      ai_move_req <= next_state == AI_TURN;
      turn <= next_state == HUMAN_TURN ? 1'b0 : next_state == AI_TURN ? 1'b1 : turn;
      request_new_move_select <= !start && rej;
      valid_move <= !start && acc;
      game_over <= next_state == DONE;
      winner <= next_winner;
      move_count <= start ? 4'd0 : (acc && move_count < 4'd9) ? move_count + 4'd1 : move_count;
      ai_timeout <= !start && (ai_timeout || tmo);
    end
  end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed scenarios with hand-computed board and status values.
module tb_turn_controller;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] human_move_select = '0, ai_move_select = '0;
  logic human_move_en = 1'b0, ai_move_en = 1'b0;
  logic ai_move_req, turn, request_new_move_select, valid_move, game_over, ai_timeout;
  logic [5:0] top, middle, bottom;
  logic [1:0] winner;
  logic [3:0] move_count;
  int total = 0, bad = 0;

  turn_controller #(.HUMAN_FIRST(1'b1), .AI_TIMEOUT(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .human_move_select(human_move_select), .human_move_en(human_move_en),
    .ai_move_select(ai_move_select), .ai_move_en(ai_move_en),
    .ai_move_req(ai_move_req), .top(top), .middle(middle), .bottom(bottom),
    .turn(turn), .request_new_move_select(request_new_move_select),
    .valid_move(valid_move), .game_over(game_over), .winner(winner),
    .move_count(move_count), .ai_timeout(ai_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic hmove(input logic [3:0] s);
    human_move_select = s;
    human_move_en = 1'b1;
    step();
    human_move_en = 1'b0;
  endtask

  task automatic amove(input logic [3:0] s);
    ai_move_select = s;
    ai_move_en = 1'b1;
    step();
    ai_move_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({top, middle, bottom} !== 18'd0) begin bad++; $display("FAIL reset_board got=%h exp=0", {top, middle, bottom}); end
    total++; if ({turn, ai_move_req, valid_move, request_new_move_select, game_over, ai_timeout} !== 6'd0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {turn, ai_move_req, valid_move, request_new_move_select, game_over, ai_timeout}); end
    total++; if ({winner, move_count} !== 6'd0) begin bad++; $display("FAIL reset_counts got=%b exp=000000", {winner, move_count}); end
    @(negedge clk);
    reset = 1'b0;
    step();
    hmove(4'd4);
    total++; if (valid_move !== 1'b0 || middle !== 6'd0) begin bad++; $display("FAIL idle_ignore got valid=%b middle=%b exp 0/000000", valid_move, middle); end
  endtask

  task automatic test_first_moves();
    do_start();
    total++; if (turn !== 1'b0 || ai_move_req !== 1'b0 || winner !== 2'b00 || game_over !== 1'b0) begin bad++; $display("FAIL start_state got turn=%b req=%b win=%b go=%b exp 0/0/00/0", turn, ai_move_req, winner, game_over); end
    hmove(4'd4);
    total++; if (middle !== 6'b000100) begin bad++; $display("FAIL h4_middle got=%b exp=000100", middle); end
    total++; if (valid_move !== 1'b1 || move_count !== 4'd1) begin bad++; $display("FAIL h4_valid got valid=%b cnt=%0d exp 1/1", valid_move, move_count); end
    total++; if (turn !== 1'b0 || ai_move_req !== 1'b0) begin bad++; $display("FAIL h4_check_phase got turn=%b req=%b exp 0/0", turn, ai_move_req); end
    step();
    total++; if (turn !== 1'b1 || ai_move_req !== 1'b1 || valid_move !== 1'b0) begin bad++; $display("FAIL ai_turn got turn=%b req=%b valid=%b exp 1/1/0", turn, ai_move_req, valid_move); end
    amove(4'd4);
    total++; if (request_new_move_select !== 1'b1 || valid_move !== 1'b0) begin bad++; $display("FAIL a4_reject got rq=%b valid=%b exp 1/0", request_new_move_select, valid_move); end
    total++; if (middle !== 6'b000100 || move_count !== 4'd1 || ai_move_req !== 1'b1) begin bad++; $display("FAIL a4_unchanged got middle=%b cnt=%0d req=%b exp 000100/1/1", middle, move_count, ai_move_req); end
    amove(4'd0);
    total++; if (top !== 6'b100000 || valid_move !== 1'b1 || request_new_move_select !== 1'b0) begin bad++; $display("FAIL a0_accept got top=%b valid=%b rq=%b exp 100000/1/0", top, valid_move, request_new_move_select); end
    step();
    total++; if (turn !== 1'b0 || ai_move_req !== 1'b0 || move_count !== 4'd2) begin bad++; $display("FAIL back_to_human got turn=%b req=%b cnt=%0d exp 0/0/2", turn, ai_move_req, move_count); end
  endtask

  task automatic test_invalid_select();
    hmove(4'd9);
    total++; if (request_new_move_select !== 1'b1 || move_count !== 4'd2) begin bad++; $display("FAIL sel9 got rq=%b cnt=%0d exp 1/2", request_new_move_select, move_count); end
    hmove(4'd15);
    total++; if (request_new_move_select !== 1'b1 || valid_move !== 1'b0 || move_count !== 4'd2) begin bad++; $display("FAIL sel15 got rq=%b valid=%b cnt=%0d exp 1/0/2", request_new_move_select, valid_move, move_count); end
    amove(4'd8);
    total++; if (valid_move !== 1'b0 || request_new_move_select !== 1'b0 || bottom !== 6'd0) begin bad++; $display("FAIL ai_ignored got valid=%b rq=%b bottom=%b exp 0/0/000000", valid_move, request_new_move_select, bottom); end
  endtask

  task automatic test_human_win();
    do_start();
    hmove(4'd0); step();
    amove(4'd3); step();
    hmove(4'd1); step();
    amove(4'd4); step();
    hmove(4'd2);
    total++; if (top !== 6'b010101 || middle !== 6'b101000 || game_over !== 1'b0) begin bad++; $display("FAIL hwin_board got top=%b mid=%b go=%b exp 010101/101000/0", top, middle, game_over); end
    step();
    total++; if (winner !== 2'b01 || game_over !== 1'b1) begin bad++; $display("FAIL hwin_result got win=%b go=%b exp 01/1", winner, game_over); end
    hmove(4'd8);
    total++; if (valid_move !== 1'b0 || bottom !== 6'd0 || game_over !== 1'b1) begin bad++; $display("FAIL done_hold got valid=%b bottom=%b go=%b exp 0/000000/1", valid_move, bottom, game_over); end
  endtask

  task automatic test_ai_win();
    do_start();
    total++; if (top !== 6'd0 || winner !== 2'b00 || game_over !== 1'b0) begin bad++; $display("FAIL restart got top=%b win=%b go=%b exp 000000/00/0", top, winner, game_over); end
    hmove(4'd0); step();
    amove(4'd3); step();
    hmove(4'd1); step();
    amove(4'd4); step();
    hmove(4'd8); step();
    amove(4'd5);
    total++; if (middle !== 6'b101010 || move_count !== 4'd6) begin bad++; $display("FAIL awin_board got mid=%b cnt=%0d exp 101010/6", middle, move_count); end
    step();
    total++; if (winner !== 2'b10 || game_over !== 1'b1 || ai_move_req !== 1'b0) begin bad++; $display("FAIL awin_result got win=%b go=%b req=%b exp 10/1/0", winner, game_over, ai_move_req); end
  endtask

  task automatic test_draw();
    do_start();
    hmove(4'd0); step();
    amove(4'd1); step();
    hmove(4'd2); step();
    amove(4'd4); step();
    hmove(4'd3); step();
    amove(4'd5); step();
    hmove(4'd7); step();
    amove(4'd6); step();
    total++; if (game_over !== 1'b0 || move_count !== 4'd8 || turn !== 1'b0) begin bad++; $display("FAIL draw_8 got go=%b cnt=%0d turn=%b exp 0/8/0", game_over, move_count, turn); end
    hmove(4'd8); step();
    total++; if (top !== 6'b011001 || middle !== 6'b011010 || bottom !== 6'b100101) begin bad++; $display("FAIL draw_board got %b %b %b exp 011001 011010 100101", top, middle, bottom); end
    total++; if (move_count !== 4'd9 || winner !== 2'b11 || game_over !== 1'b1) begin bad++; $display("FAIL draw_result got cnt=%0d win=%b go=%b exp 9/11/1", move_count, winner, game_over); end
  endtask

  task automatic test_timeout();
    do_start();
    hmove(4'd0); step();
    step(); step();
    human_move_select = 4'd5; human_move_en = 1'b1; step(); human_move_en = 1'b0;
    total++; if (valid_move !== 1'b0 || middle !== 6'd0) begin bad++; $display("FAIL human_ignored got valid=%b mid=%b exp 0/000000", valid_move, middle); end
    amove(4'd0);
    total++; if (request_new_move_select !== 1'b1) begin bad++; $display("FAIL to_reject got rq=%b exp 1", request_new_move_select); end
    step();
    total++; if (game_over !== 1'b0 || ai_timeout !== 1'b0 || ai_move_req !== 1'b1) begin bad++; $display("FAIL to_early got go=%b to=%b req=%b exp 0/0/1", game_over, ai_timeout, ai_move_req); end
    step();
    total++; if (ai_timeout !== 1'b1 || winner !== 2'b01 || game_over !== 1'b1 || ai_move_req !== 1'b0) begin bad++; $display("FAIL to_fire got to=%b win=%b go=%b req=%b exp 1/01/1/0", ai_timeout, winner, game_over, ai_move_req); end
  endtask

  task automatic test_start_priority();
    do_start();
    total++; if (ai_timeout !== 1'b0 || winner !== 2'b00) begin bad++; $display("FAIL start_clear got to=%b win=%b exp 0/00", ai_timeout, winner); end
    hmove(4'd0); step();
    amove(4'd4); step();
    start = 1'b1; human_move_select = 4'd8; human_move_en = 1'b1;
    step();
    start = 1'b0; human_move_en = 1'b0;
    total++; if (valid_move !== 1'b0 || request_new_move_select !== 1'b0) begin bad++; $display("FAIL prio_pulse got valid=%b rq=%b exp 0/0", valid_move, request_new_move_select); end
    total++; if ({top, middle, bottom} !== 18'd0 || move_count !== 4'd0 || turn !== 1'b0) begin bad++; $display("FAIL prio_clear got board=%h cnt=%0d turn=%b exp 0/0/0", {top, middle, bottom}, move_count, turn); end
    hmove(4'd8);
    total++; if (bottom !== 6'b000001 || move_count !== 4'd1) begin bad++; $display("FAIL prio_resume got bottom=%b cnt=%0d exp 000001/1", bottom, move_count); end
  endtask

  task automatic test_async_reset();
    step();
    total++; if (ai_move_req !== 1'b1 || turn !== 1'b1) begin bad++; $display("FAIL pre_reset got req=%b turn=%b exp 1/1", ai_move_req, turn); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (ai_move_req !== 1'b0 || turn !== 1'b0 || bottom !== 6'd0 || move_count !== 4'd0) begin bad++; $display("FAIL async_reset got req=%b turn=%b bottom=%b cnt=%0d exp 0/0/000000/0", ai_move_req, turn, bottom, move_count); end
    @(negedge clk);
    reset = 1'b0;
    step();
    total++; if (game_over !== 1'b0 || winner !== 2'b00 || ai_move_req !== 1'b0) begin bad++; $display("FAIL post_reset got go=%b win=%b req=%b exp 0/00/0", game_over, winner, ai_move_req); end
  endtask

  initial begin
    test_reset();
    test_first_moves();
    test_invalid_select();
    test_human_win();
    test_ai_win();
    test_draw();
    test_timeout();
    test_start_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
